// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared JK encodings and load clamping for the JK up/down counter
package counter_pkg;

    // {J, K} pair driven into one JK flip-flop
    typedef logic [1:0] jk_t;

    localparam jk_t JK_HOLD = 2'b00;
    localparam jk_t JK_CLR  = 2'b01;
    localparam jk_t JK_SET  = 2'b10;
    localparam jk_t JK_TGL  = 2'b11;

    // Limit a load value to the legal count range 0..mod-1
    function automatic logic [31:0] clamp_to_mod(input logic [31:0] value, input logic [31:0] mod);
        if (value > mod - 32'd1) begin
            return mod - 32'd1;
        end
        return value;
    endfunction

endpackage

// File: rtl/jk_ff.sv
// rtl/jk_ff.sv - single-bit JK flip-flop with asynchronous active-low reset
module jk_ff
    import counter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_d;
    logic q_q;

    // JK characteristic: hold, clear, set or toggle
    always_comb begin
        q_d = q_q;
        case ({j, k})
            JK_HOLD: q_d = q_q;
            JK_CLR:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            JK_TGL:  q_d = ~q_q;
        endcase
    end

    // State register, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sync_updown_jk_counter.sv
// rtl/sync_updown_jk_counter.sv - parametrised up/down modulus counter built from JK flip-flops
module sync_updown_jk_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MOD      = 2 ** WIDTH,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic [WIDTH-1:0]      cnt_q;
    logic [WIDTH-1:0]      load_val;
    logic [WIDTH-1:0]      wrap_target;
    jk_t  [WIDTH-1:0]      jk;
    logic                  at_max;
    logic                  at_zero;
    logic                  boundary;
    logic                  chain;
    logic                  wrap_d;
    logic                  wrap_q;

    assign load_val    = WIDTH'(clamp_to_mod(32'(din), 32'(MOD)));
    assign wrap_target = up ? '0 : MAX_VAL;

    // Detect an enabled count that would step past either end of the range
    always_comb begin
        at_max   = (cnt_q == MAX_VAL);
        at_zero  = (cnt_q == '0);
        boundary = en & ((up & at_max) | (~up & at_zero));
    end

    // J/K excitation: binary toggle chain, overridden by load, wrap or saturate
    always_comb begin
        jk    = '{default: JK_HOLD};
        chain = en;
        for (int i = 0; i < WIDTH; i++) begin
            jk[i] = chain ? JK_TGL : JK_HOLD;
            chain = chain & (up ? cnt_q[i] : ~cnt_q[i]);
        end
        if (load) begin
            for (int i = 0; i < WIDTH; i++) begin
                jk[i] = load_val[i] ? JK_SET : JK_CLR;
            end
        end else if (boundary) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (SATURATE == 0) begin
                    jk[i] = wrap_target[i] ? JK_SET : JK_CLR;
                end else begin
                    jk[i] = JK_HOLD;
                end
            end
        end
    end

    // Counter bits, one JK flip-flop each
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff u_jk_ff (
            .clk   (clk),
            .rst_n (reset),
            .j     (jk[i][1]),
            .k     (jk[i][0]),
            .q     (cnt_q[i])
        );
    end

    // A wrap happens only on an enabled, non-load boundary step in wrap mode
    always_comb begin
        wrap_d = 1'b0;
        if (!load && boundary && (SATURATE == 0)) begin
            wrap_d = 1'b1;
        end
    end

    // Wrap pulse register, one cycle after the wrapping edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign q    = cnt_q;
    assign wrap = wrap_q;
    assign tc   = boundary & ~load;

endmodule

// File: tb/tb_sync_updown_jk_counter.sv
// tb/tb_sync_updown_jk_counter.sv - self-checking bench for sync_updown_jk_counter
module tb_sync_updown_jk_counter;

    localparam int N = 8;
    localparam int W_T [N] = '{2, 4, 4, 1, 3, 3, 8, 8};
    localparam int M_T [N] = '{4, 10, 10, 2, 5, 8, 200, 256};
    localparam int S_T [N] = '{0, 0, 1, 0, 1, 0, 0, 1};

    logic        clk;
    logic        reset;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] din;

    logic [15:0] q_all    [N];
    logic        tc_all   [N];
    logic        wrap_all [N];

    int total;
    int bad;
    int mq [N];
    int mw [N];

    int t1_q [5] = '{3, 2, 1, 0, 3};
    int t1_w [5] = '{1, 0, 0, 0, 1};

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [W_T[g]-1:0] q_w;
        logic              tc_w;
        logic              wrap_w;
        sync_updown_jk_counter #(
            .WIDTH    (W_T[g]),
            .MOD      (M_T[g]),
            .SATURATE (S_T[g])
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .up    (up),
            .load  (load),
            .din   (din[W_T[g]-1:0]),
            .q     (q_w),
            .tc    (tc_w),
            .wrap  (wrap_w)
        );
        assign q_all[g]    = 16'(q_w);
        assign tc_all[g]   = tc_w;
        assign wrap_all[g] = wrap_w;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called just after a falling edge: assert reset between edges and check the async clear
    task automatic apply_reset();
        #2;
        reset = 1'b0;
        #1;
        for (int g = 0; g < N; g++) begin
            check($sformatf("rst_q%0d", g), 32'(q_all[g]), 32'd0);
            check($sformatf("rst_wrap%0d", g), 32'(wrap_all[g]), 32'd0);
            mq[g] = 0;
            mw[g] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Called just after a falling edge with inputs set: check tc, clock once, check q and wrap
    task automatic tick();
        int nq [N];
        int nw [N];
        int m;
        int v;
        #1;
        for (int g = 0; g < N; g++) begin
            m = M_T[g];
            check($sformatf("tc%0d", g), 32'(tc_all[g]),
                  32'(en && !load && ((up && mq[g] == m - 1) || (!up && mq[g] == 0))));
            nq[g] = mq[g];
            nw[g] = 0;
            if (load) begin
                v = int'(din) % (1 << W_T[g]);
                nq[g] = (v > m - 1) ? m - 1 : v;
            end else if (en && up) begin
                if (mq[g] < m - 1) nq[g] = mq[g] + 1;
                else if (S_T[g] == 0) begin nq[g] = 0; nw[g] = 1; end
            end else if (en) begin
                if (mq[g] > 0) nq[g] = mq[g] - 1;
                else if (S_T[g] == 0) begin nq[g] = m - 1; nw[g] = 1; end
            end
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            mq[g] = nq[g];
            mw[g] = nw[g];
            check($sformatf("q%0d", g), 32'(q_all[g]), 32'(mq[g]));
            check($sformatf("wrap%0d", g), 32'(wrap_all[g]), 32'(mw[g]));
            check($sformatf("range%0d", g), 32'(int'(q_all[g]) < M_T[g]), 32'd1);
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        en    = 1'b0;
        up    = 1'b0;
        load  = 1'b0;
        din   = '0;
        @(negedge clk);
        apply_reset();

        // Mod-4 down count through two wraps
        en = 1'b1; up = 1'b0; load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t1_q", 32'(q_all[0]), 32'(t1_q[k]));
            check("t1_wrap", 32'(wrap_all[0]), 32'(t1_w[k]));
        end

        // Mod-10 up count with tc at 9 and a single wrap
        apply_reset();
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 11; k++) begin
            #1;
            check("t2_tc", 32'(tc_all[1]), 32'(k == 9));
            tick();
            check("t2_q", 32'(q_all[1]), 32'((k + 1) % 10));
            check("t2_wrap", 32'(wrap_all[1]), 32'(k == 9));
        end

        // Saturating mod-10 holds at both ends
        load = 1'b1; din = 16'd8; tick();
        load = 1'b0; en = 1'b1; up = 1'b1; tick();
        check("t3_top", 32'(q_all[2]), 32'd9);
        #1;
        check("t3_tc_top", 32'(tc_all[2]), 32'd1);
        tick();
        check("t3_hold_top", 32'(q_all[2]), 32'd9);
        check("t3_nowrap_top", 32'(wrap_all[2]), 32'd0);
        load = 1'b1; din = 16'd1; tick();
        load = 1'b0; up = 1'b0; tick();
        check("t3_bot", 32'(q_all[2]), 32'd0);
        #1;
        check("t3_tc_bot", 32'(tc_all[2]), 32'd1);
        tick();
        check("t3_hold_bot", 32'(q_all[2]), 32'd0);
        check("t3_nowrap_bot", 32'(wrap_all[2]), 32'd0);

        // Load clamps and overrides a boundary count
        load = 1'b1; din = 16'd12; en = 1'b1; up = 1'b1; tick();
        check("t4_clamp", 32'(q_all[1]), 32'd9);
        din = 16'd5; tick();
        check("t4_load", 32'(q_all[1]), 32'd5);
        check("t4_nowrap", 32'(wrap_all[1]), 32'd0);

        // Asynchronous reset mid-count
        load = 1'b1; din = 16'd6; tick();
        load = 1'b0; en = 1'b1; up = 1'b1; tick();
        check("t5_pre", 32'(q_all[1]), 32'd7);
        apply_reset();
        en = 1'b1; up = 1'b1; load = 1'b0; tick();
        check("t5_post", 32'(q_all[1]), 32'd1);

        // Randomised traffic against the model
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 499) == 0) apply_reset();
            en   = ($urandom_range(0, 3) != 0);
            up   = 1'($urandom);
            load = ($urandom_range(0, 15) == 0);
            din  = 16'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
